// File: rtl/branch_predictor.sv
// BTB + optional 2-bit BHT fetch predictor with resolution statistics.
// Define BRANCH_PREDICTOR_BHT_EN to build the BHT; otherwise 1-bit BTB-valid prediction.
module branch_predictor #(
  parameter int BTB_ADDR_LEN = 6,
  parameter int BHT_ADDR_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] npc_pred,
  input  logic        update_en,
  input  logic [31:0] pc_ex,
  input  logic        br_taken_ex,
  input  logic [31:0] br_target_ex,
  input  logic        pred_taken_ex,
  output logic        mispredict,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int BTB_N = 1 << BTB_ADDR_LEN;
  localparam int TAG_W = 30 - BTB_ADDR_LEN;

  logic [BTB_N-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag    [BTB_N];
  logic [31:0]      btb_target [BTB_N];

  logic [BTB_ADDR_LEN-1:0] if_idx;
  logic [BTB_ADDR_LEN-1:0] ex_idx;
  logic [TAG_W-1:0]        if_tag;
  logic [TAG_W-1:0]        ex_tag;
  logic                    btb_hit;
  logic                    ex_hit;
  logic [31:0]             if_target;
  logic [31:0]             ex_target;
  logic                    unused;

  assign unused    = ^{pc_if[1:0], pc_ex[1:0]};
  assign if_idx    = pc_if[BTB_ADDR_LEN+1:2];
  assign ex_idx    = pc_ex[BTB_ADDR_LEN+1:2];
  assign if_tag    = pc_if[31:BTB_ADDR_LEN+2];
  assign ex_tag    = pc_ex[31:BTB_ADDR_LEN+2];
  assign if_target = btb_target[if_idx];
  assign ex_target = btb_target[ex_idx];
  assign btb_hit   = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign ex_hit    = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);

`ifdef BRANCH_PREDICTOR_BHT_EN
  localparam int BHT_N = 1 << BHT_ADDR_LEN;

  logic [1:0]              bht [BHT_N];
  logic [BHT_ADDR_LEN-1:0] if_bidx;
  logic [BHT_ADDR_LEN-1:0] ex_bidx;

  assign if_bidx    = pc_if[BHT_ADDR_LEN+1:2];
  assign ex_bidx    = pc_ex[BHT_ADDR_LEN+1:2];
  assign pred_taken = btb_hit & bht[if_bidx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (update_en) begin
      if (br_taken_ex && bht[ex_bidx] != 2'b11)
        bht[ex_bidx] <= bht[ex_bidx] + 2'b01;
      else if (!br_taken_ex && bht[ex_bidx] != 2'b00)
        bht[ex_bidx] <= bht[ex_bidx] - 2'b01;
    end
  end

  logic unused_ex_hit;
  assign unused_ex_hit = ex_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (update_en && br_taken_ex) begin
      btb_valid[ex_idx] <= 1'b1;
    end
  end
`else
  assign pred_taken = btb_hit;

  // Not-taken resolution drops a matching entry: 1-bit prediction.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (update_en) begin
      if (br_taken_ex)
        btb_valid[ex_idx] <= 1'b1;
      else if (ex_hit)
        btb_valid[ex_idx] <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst && update_en && br_taken_ex) begin
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= br_target_ex;
    end
  end

  assign npc_pred = pred_taken ? if_target : pc_if + 32'd4;

  assign mispredict = update_en &
    ((pred_taken_ex != br_taken_ex) |
     (br_taken_ex & pred_taken_ex & (ex_target != br_target_ex)));

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (update_en)  branch_cnt <= branch_cnt + 32'd1;
      if (mispredict) miss_cnt   <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_if = 32'h0;
  logic        pred_taken;
  logic [31:0] npc_pred;
  logic        update_en = 1'b0;
  logic [31:0] pc_ex = 32'h0;
  logic        br_taken_ex = 1'b0;
  logic [31:0] br_target_ex = 32'h0;
  logic        pred_taken_ex = 1'b0;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_miss = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .pc_if(pc_if),
    .pred_taken(pred_taken), .npc_pred(npc_pred),
    .update_en(update_en), .pc_ex(pc_ex),
    .br_taken_ex(br_taken_ex), .br_target_ex(br_target_ex),
    .pred_taken_ex(pred_taken_ex), .mispredict(mispredict),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic pex);
    @(negedge clk);
    update_en = 1'b1; pc_ex = pc; br_taken_ex = tk;
    br_target_ex = tgt; pred_taken_ex = pex;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    update_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pc_if = 32'h1C;
    #1;
    checks++;
    if (branch_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", branch_cnt, miss_cnt);
    end
    checks++;
    if (pred_taken !== 1'b0 || npc_pred !== 32'h20) begin
      errors++;
      $display("FAIL reset_pred got %b/%h want 0/00000020", pred_taken, npc_pred);
    end
    pc_if = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || npc_pred !== 32'h0) begin
      errors++;
      $display("FAIL wrap_npc got %b/%h want 0/00000000", pred_taken, npc_pred);
    end
    exp_br = 0;
    exp_miss = 0;
  endtask

  task automatic test_train();
    pc_if = 32'h1C;
    upd(32'h1C, 1'b1, 32'h10, 1'b0);
    checks++;
    if (pred_taken !== 1'b0 || npc_pred !== 32'h20) begin
      errors++;
      $display("FAIL same_cycle got %b/%h want 0/00000020", pred_taken, npc_pred);
    end
    checks++;
    if (mispredict !== 1'b1) begin
      errors++;
      $display("FAIL train_mp got %b want 1", mispredict);
    end
    exp_br++; exp_miss++;
    idle();
    checks++;
    if (pred_taken !== 1'b1 || npc_pred !== 32'h10) begin
      errors++;
      $display("FAIL trained got %b/%h want 1/00000010", pred_taken, npc_pred);
    end
    checks++;
    if (branch_cnt !== exp_br || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL train_cnt got %0d/%0d want %0d/%0d",
               branch_cnt, miss_cnt, exp_br, exp_miss);
    end
  endtask

  task automatic test_alias();
    pc_if = 32'h11C;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || npc_pred !== 32'h120) begin
      errors++;
      $display("FAIL alias got %b/%h want 0/00000120", pred_taken, npc_pred);
    end
    pc_if = 32'h1C;
  endtask

  task automatic test_target();
    upd(32'h1C, 1'b1, 32'h40, 1'b1);
    checks++;
    if (mispredict !== 1'b1) begin
      errors++;
      $display("FAIL tgt_mp got %b want 1", mispredict);
    end
    exp_br++; exp_miss++;
    upd(32'h1C, 1'b1, 32'h40, 1'b1);
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL tgt_ok got %b want 0", mispredict);
    end
    exp_br++;
    idle();
    checks++;
    if (pred_taken !== 1'b1 || npc_pred !== 32'h40) begin
      errors++;
      $display("FAIL new_tgt got %b/%h want 1/00000040", pred_taken, npc_pred);
    end
    checks++;
    if (branch_cnt !== exp_br || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL tgt_cnt got %0d/%0d want %0d/%0d",
               branch_cnt, miss_cnt, exp_br, exp_miss);
    end
  endtask

  task automatic test_not_taken();
`ifdef BRANCH_PREDICTOR_BHT_EN
    // counter is 3 here after three taken updates; one more stays at 3
    upd(32'h1C, 1'b1, 32'h40, 1'b1);
    exp_br++;
    upd(32'h1C, 1'b0, 32'h0, 1'b1);
    exp_br++; exp_miss++;
    idle();
    checks++;
    if (pred_taken !== 1'b1 || npc_pred !== 32'h40) begin
      errors++;
      $display("FAIL hyst got %b/%h want 1/00000040", pred_taken, npc_pred);
    end
`endif
    upd(32'h1C, 1'b0, 32'h0, 1'b1);
    checks++;
    if (mispredict !== 1'b1) begin
      errors++;
      $display("FAIL nt_mp got %b want 1", mispredict);
    end
    exp_br++; exp_miss++;
    idle();
    checks++;
    if (pred_taken !== 1'b0 || npc_pred !== 32'h20) begin
      errors++;
      $display("FAIL nt_pred got %b/%h want 0/00000020", pred_taken, npc_pred);
    end
    checks++;
    if (branch_cnt !== exp_br || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL nt_cnt got %0d/%0d want %0d/%0d",
               branch_cnt, miss_cnt, exp_br, exp_miss);
    end
  endtask

  task automatic test_back_to_back();
    upd(32'h1C, 1'b1, 32'h10, 1'b0);
    upd(32'h80, 1'b1, 32'h200, 1'b0);
    exp_br += 2; exp_miss += 2;
    idle();
    pc_if = 32'h1C;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || npc_pred !== 32'h10) begin
      errors++;
      $display("FAIL b2b_a got %b/%h want 1/00000010", pred_taken, npc_pred);
    end
    pc_if = 32'h80;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || npc_pred !== 32'h200) begin
      errors++;
      $display("FAIL b2b_b got %b/%h want 1/00000200", pred_taken, npc_pred);
    end
    checks++;
    if (branch_cnt !== exp_br || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL b2b_cnt got %0d/%0d want %0d/%0d",
               branch_cnt, miss_cnt, exp_br, exp_miss);
    end
  endtask

  task automatic test_reset_update();
    @(negedge clk);
    rst = 1'b1;
    update_en = 1'b1; pc_ex = 32'h44; br_taken_ex = 1'b1;
    br_target_ex = 32'h300; pred_taken_ex = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    update_en = 1'b0;
    pc_if = 32'h44;
    #1;
    exp_br = 0; exp_miss = 0;
    checks++;
    if (pred_taken !== 1'b0 || npc_pred !== 32'h48) begin
      errors++;
      $display("FAIL rst_upd got %b/%h want 0/00000048", pred_taken, npc_pred);
    end
    checks++;
    if (branch_cnt !== exp_br || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL rst_cnt got %0d/%0d want 0/0", branch_cnt, miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_alias();
    test_target();
    test_not_taken();
    test_back_to_back();
    test_reset_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
